// File: rtl/pcs_pkg.sv
// ---------------------------------------------------------------------------
// pcs_pkg
//   Shared definitions for the GMII receive frame checker:
//     - state_t        : receive FSM states (IDLE / PRE / DATA / DROP)
//     - PREAMBLE_BYTE  : 8'h55 preamble octet
//     - SFD_BYTE       : 8'hD5 start-of-frame delimiter
//     - CRC32_POLY     : reflected Ethernet CRC-32 polynomial
//     - CRC32_INIT     : CRC register seed
//     - CRC32_RESIDUE  : register value left after running a frame plus its
//                        intact FCS through the CRC
//     - sat_inc16()    : 16-bit saturating increment for the frame counters
// ---------------------------------------------------------------------------
package pcs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_rx_frame_checker_crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
//   Combinational CRC-32 next-state function, one byte per step, LSB-first
//   (reflected) as used by Ethernet. No final inversion is applied; the
//   caller compares the register against the residue constant.
// Ports
//   crc_i   in  32  current CRC register
//   data_i  in  8   byte to absorb
//   crc_o   out 32  CRC register after absorbing data_i
// ---------------------------------------------------------------------------
module crc32_d8
  import pcs_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// ---------------------------------------------------------------------------
// gmii_rx_frame_checker
//   Sink for the GMII receive side of the PCS. Strips preamble/SFD, streams
//   the frame bytes (DA..FCS) with sof/eof markers, measures the length,
//   flags runt/oversize (and optionally CRC) errors and keeps saturating
//   good/bad frame counters.
//
//   Optional feature macro: GMII_RX_CRC_CHECK_EN
//     defined   : CRC-32 checked over DA..FCS, crc_err_o reports mismatches
//     undefined : no CRC logic, crc_err_o tied to 0
//
// Ports
//   GTX_CLK        in   1      clock, rising edge
//   mr_main_reset  in   1      asynchronous active-low reset
//   RX_DV          in   1      GMII receive data valid
//   RXD            in   8      GMII receive byte
//   rx_data_o      out  8      frame byte
//   rx_valid_o     out  1      rx_data_o valid (single-cycle pulse per byte)
//   rx_sof_o       out  1      first frame byte
//   rx_eof_o       out  1      last frame byte
//   rx_err_o       out  1      frame bad, only meaningful with rx_eof_o
//   crc_err_o      out  1      FCS mismatch, only meaningful with rx_eof_o
//   frame_len_o    out  CNT_W  length of the last frame, updated at eof
//   frame_cnt_o    out  16     good frames, saturating
//   err_cnt_o      out  16     bad or dropped frames, saturating
//   dbg_state_o    out  2      current FSM state (pcs_pkg::state_t encoding)
//
// Stream handshake: valid-only. A beat is transferred on every cycle that
// rx_valid_o is high; there is no ready, so the sink must take every beat.
// ---------------------------------------------------------------------------
module gmii_rx_frame_checker
  import pcs_pkg::*;
#(
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518,
  parameter int PREAMBLE_MIN = 1,
  parameter int CNT_W        = 11
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             RX_DV,
  input  logic [7:0]       RXD,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_sof_o,
  output logic             rx_eof_o,
  output logic             rx_err_o,
  output logic             crc_err_o,
  output logic [CNT_W-1:0] frame_len_o,
  output logic [15:0]      frame_cnt_o,
  output logic [15:0]      err_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam logic [CNT_W-1:0] LEN_SAT = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             hold_first_q, hold_first_d;

  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_sof_q, rx_sof_d;
  logic             rx_eof_q, rx_eof_d;
  logic             rx_err_q, rx_err_d;
  logic             crc_err_q, crc_err_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             sfd_ok;
  logic             crc_bad;
  logic             len_bad;
  logic [CNT_W-1:0] len_inc;

  assign sfd_ok  = RX_DV && (RXD == SFD_BYTE) && (pre_cnt_q >= 8'(PREAMBLE_MIN));
  assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
  assign len_bad = (len_q < CNT_W'(MIN_FRAME)) || (len_q > CNT_W'(MAX_FRAME));

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (RXD),
    .crc_o  (crc_next)
  );

  // Reseeded on the SFD so each frame starts clean; FCS bytes are absorbed
  // like data, leaving the fixed residue for an intact frame.
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_PRE && sfd_ok) begin
      crc_d = CRC32_INIT;
    end else if (state_q == ST_DATA && RX_DV) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_bad = (crc_q != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    hold_first_d = hold_first_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_sof_d     = 1'b0;
    rx_eof_d     = 1'b0;
    rx_err_d     = 1'b0;
    crc_err_d    = 1'b0;
    frame_len_d  = frame_len_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (RX_DV) begin
          if (RXD == PREAMBLE_BYTE) begin
            state_d   = ST_PRE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d   = ST_DROP;
            err_cnt_d = sat_inc16(err_cnt_q);
          end
        end
      end

      ST_PRE: begin
        if (!RX_DV) begin
          state_d   = ST_IDLE;
          err_cnt_d = sat_inc16(err_cnt_q);
        end else if (RXD == PREAMBLE_BYTE) begin
          pre_cnt_d = (pre_cnt_q == 8'hFF) ? pre_cnt_q : pre_cnt_q + 8'd1;
        end else if (sfd_ok) begin
          state_d    = ST_DATA;
          len_d      = '0;
          hold_vld_d = 1'b0;
        end else begin
          state_d   = ST_DROP;
          err_cnt_d = sat_inc16(err_cnt_q);
        end
      end

      ST_DATA: begin
        if (RX_DV) begin
          // The held byte is only released once we know another byte
          // follows, so eof can be attached to the true last byte.
          if (hold_vld_q) begin
            rx_data_d  = hold_q;
            rx_valid_d = 1'b1;
            rx_sof_d   = hold_first_q;
          end
          hold_d       = RXD;
          hold_vld_d   = 1'b1;
          hold_first_d = !hold_vld_q;
          len_d        = len_inc;
        end else begin
          state_d    = ST_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            rx_data_d   = hold_q;
            rx_valid_d  = 1'b1;
            rx_sof_d    = hold_first_q;
            rx_eof_d    = 1'b1;
            rx_err_d    = len_bad || crc_bad;
            crc_err_d   = crc_bad;
            frame_len_d = len_q;
            if (len_bad || crc_bad) begin
              err_cnt_d = sat_inc16(err_cnt_q);
            end else begin
              frame_cnt_d = sat_inc16(frame_cnt_q);
            end
          end else begin
            // SFD immediately followed by end of carrier: nothing to emit.
            err_cnt_d = sat_inc16(err_cnt_q);
          end
        end
      end

      ST_DROP: begin
        if (!RX_DV) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      hold_first_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      rx_eof_q     <= 1'b0;
      rx_err_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      frame_len_q  <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      hold_first_q <= hold_first_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sof_q     <= rx_sof_d;
      rx_eof_q     <= rx_eof_d;
      rx_err_q     <= rx_err_d;
      crc_err_q    <= crc_err_d;
      frame_len_q  <= frame_len_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_sof_o    = rx_sof_q;
  assign rx_eof_o    = rx_eof_q;
  assign rx_err_o    = rx_err_q;
  assign crc_err_o   = crc_err_q;
  assign frame_len_o = frame_len_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_gmii_rx_frame_checker
//   Directed bench for gmii_rx_frame_checker. Frames carry a real Ethernet
//   FCS computed here; a monitor checks every emitted byte against exp_q and
//   counts beats, sof and eof markers. Each test task checks its own results.
// ---------------------------------------------------------------------------
module tb_gmii_rx_frame_checker;
  import pcs_pkg::*;

  localparam int CNT_W = 11;

  logic             GTX_CLK = 1'b0;
  logic             mr_main_reset;
  logic             RX_DV;
  logic [7:0]       RXD;
  logic [7:0]       rx_data_o;
  logic             rx_valid_o;
  logic             rx_sof_o;
  logic             rx_eof_o;
  logic             rx_err_o;
  logic             crc_err_o;
  logic [CNT_W-1:0] frame_len_o;
  logic [15:0]      frame_cnt_o;
  logic [15:0]      err_cnt_o;
  logic [1:0]       dbg_state_o;

  int checks = 0;
  int errors = 0;

  // monitor / scoreboard state
  logic [7:0] exp_q[$];
  int         beats  = 0;
  int         sofs   = 0;
  int         eofs   = 0;
  int         sof_at = 0;
  int         eof_at = 0;
  int         sb_bad = 0;
  logic       eof_err = 1'b0;
  logic       eof_crc = 1'b0;

  gmii_rx_frame_checker #(
    .MIN_FRAME    (64),
    .MAX_FRAME    (1518),
    .PREAMBLE_MIN (1),
    .CNT_W        (CNT_W)
  ) dut (
    .GTX_CLK       (GTX_CLK),
    .mr_main_reset (mr_main_reset),
    .RX_DV         (RX_DV),
    .RXD           (RXD),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_sof_o      (rx_sof_o),
    .rx_eof_o      (rx_eof_o),
    .rx_err_o      (rx_err_o),
    .crc_err_o     (crc_err_o),
    .frame_len_o   (frame_len_o),
    .frame_cnt_o   (frame_cnt_o),
    .err_cnt_o     (err_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 GTX_CLK = ~GTX_CLK;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge GTX_CLK) begin
    logic [7:0] e;
    if (rx_valid_o === 1'b1) begin
      beats = beats + 1;
      if (rx_sof_o === 1'b1) begin
        sofs   = sofs + 1;
        sof_at = beats;
      end
      if (rx_eof_o === 1'b1) begin
        eofs    = eofs + 1;
        eof_at  = beats;
        eof_err = rx_err_o;
        eof_crc = crc_err_o;
      end
      if (exp_q.size() == 0) begin
        sb_bad = sb_bad + 1;
      end else begin
        e = exp_q.pop_front();
        if (e !== rx_data_o) sb_bad = sb_bad + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    RX_DV = 1'b1;
    RXD   = b;
    @(posedge GTX_CLK); #1;
  endtask

  task automatic idle(input int n);
    RX_DV = 1'b0;
    RXD   = 8'h00;
    repeat (n) begin
      @(posedge GTX_CLK); #1;
    end
  endtask

  // 7x55, D5, (len-4) pattern bytes, 4 FCS bytes LSB first, then gap idle cycles
  task automatic send_frame(input int len, input bit corrupt, input int gap);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < len - 4; i++) begin
      b = 8'((i * 29 + len) & 255);
      c = crc_step(c, b);
      exp_q.push_back(b);
      drive_byte(b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      if (corrupt && k == 3) b = b ^ 8'h01;
      exp_q.push_back(b);
      drive_byte(b);
    end
    idle(gap);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [55:0] outs;
    mr_main_reset = 1'b0;
    RX_DV = 1'b0;
    RXD   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      RX_DV = i[0];
      RXD   = 8'h55;
      @(posedge GTX_CLK); #1;
    end
    outs = {rx_data_o, rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, crc_err_o,
            frame_len_o, frame_cnt_o, err_cnt_o};
    checks++;
    if (outs !== 56'h0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", outs);
    end
    checks++;
    if (dbg_state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state_o, ST_IDLE);
    end
    RX_DV = 1'b0;
    RXD   = 8'h00;
    mr_main_reset = 1'b1;
    idle(4);
    outs = {rx_data_o, rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, crc_err_o,
            frame_len_o, frame_cnt_o, err_cnt_o};
    checks++;
    if (outs !== 56'h0 || beats !== 0) begin
      errors++;
      $display("FAIL post_reset_outs got %h beats %0d exp 0", outs, beats);
    end
  endtask

  task automatic test_good_frame();
    int b0, s0, e0, k0;
    b0 = beats; s0 = sofs; e0 = eofs; k0 = sb_bad;
    send_frame(64, 1'b0, 2);
    checks++;
    if (beats - b0 !== 64) begin
      errors++;
      $display("FAIL good_beats got %0d exp 64", beats - b0);
    end
    checks++;
    if (sofs - s0 !== 1 || sof_at !== b0 + 1) begin
      errors++;
      $display("FAIL good_sof got count %0d at %0d exp 1 at %0d", sofs - s0, sof_at, b0 + 1);
    end
    checks++;
    if (eofs - e0 !== 1 || eof_at !== b0 + 64) begin
      errors++;
      $display("FAIL good_eof got count %0d at %0d exp 1 at %0d", eofs - e0, eof_at, b0 + 64);
    end
    checks++;
    if (sb_bad !== k0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL good_data got %0d bad bytes, %0d left exp 0", sb_bad - k0, exp_q.size());
    end
    checks++;
    if (frame_len_o !== 11'd64) begin
      errors++;
      $display("FAIL good_len got %0d exp 64", frame_len_o);
    end
    checks++;
    if (eof_err !== 1'b0 || eof_crc !== 1'b0) begin
      errors++;
      $display("FAIL good_err got err %b crc %b exp 0 0", eof_err, eof_crc);
    end
    checks++;
    if (frame_cnt_o !== 16'd1 || err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL good_cnt got frames %0d errs %0d exp 1 0", frame_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_length_errors();
    int b0, k0;
    b0 = beats; k0 = sb_bad;
    send_frame(60, 1'b0, 2);
    checks++;
    if (eof_err !== 1'b1 || frame_len_o !== 11'd60 || beats - b0 !== 60) begin
      errors++;
      $display("FAIL runt got err %b len %0d beats %0d exp 1 60 60", eof_err, frame_len_o, beats - b0);
    end
    checks++;
    if (err_cnt_o !== 16'd1 || frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL runt_cnt got errs %0d frames %0d exp 1 1", err_cnt_o, frame_cnt_o);
    end
    b0 = beats;
    send_frame(1519, 1'b0, 2);
    checks++;
    if (eof_err !== 1'b1 || frame_len_o !== 11'd1519 || beats - b0 !== 1519) begin
      errors++;
      $display("FAIL oversize got err %b len %0d beats %0d exp 1 1519 1519", eof_err, frame_len_o, beats - b0);
    end
    checks++;
    if (err_cnt_o !== 16'd2 || frame_cnt_o !== 16'd1 || sb_bad !== k0) begin
      errors++;
      $display("FAIL oversize_cnt got errs %0d frames %0d bad %0d exp 2 1 0", err_cnt_o, frame_cnt_o, sb_bad - k0);
    end
  endtask

  task automatic test_drop();
    int b0;
    b0 = beats;
    drive_byte(8'h00); drive_byte(8'h11); drive_byte(8'h22);
    checks++;
    if (dbg_state_o !== ST_DROP) begin
      errors++;
      $display("FAIL drop_state got %0d exp %0d", dbg_state_o, ST_DROP);
    end
    idle(2);
    checks++;
    if (dbg_state_o !== ST_IDLE || err_cnt_o !== 16'd3 || beats !== b0) begin
      errors++;
      $display("FAIL drop_junk got state %0d errs %0d beats %0d exp 0 3 0", dbg_state_o, err_cnt_o, beats - b0);
    end
    drive_byte(8'h55); drive_byte(8'h55); drive_byte(8'hAA);
    drive_byte(8'h12); drive_byte(8'h34);
    checks++;
    if (dbg_state_o !== ST_DROP) begin
      errors++;
      $display("FAIL bad_pre_state got %0d exp %0d", dbg_state_o, ST_DROP);
    end
    idle(2);
    checks++;
    if (dbg_state_o !== ST_IDLE || err_cnt_o !== 16'd4 || beats !== b0 || frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL bad_pre got state %0d errs %0d beats %0d frames %0d exp 0 4 0 1",
               dbg_state_o, err_cnt_o, beats - b0, frame_cnt_o);
    end
  endtask

  task automatic test_crc_error();
    int b0;
    b0 = beats;
    send_frame(64, 1'b1, 2);
    checks++;
    if (beats - b0 !== 64 || frame_len_o !== 11'd64) begin
      errors++;
      $display("FAIL crc_frame got beats %0d len %0d exp 64 64", beats - b0, frame_len_o);
    end
`ifdef GMII_RX_CRC_CHECK_EN
    checks++;
    if (eof_crc !== 1'b1 || eof_err !== 1'b1) begin
      errors++;
      $display("FAIL crc_flag got crc %b err %b exp 1 1", eof_crc, eof_err);
    end
    checks++;
    if (frame_cnt_o !== 16'd1 || err_cnt_o !== 16'd5) begin
      errors++;
      $display("FAIL crc_cnt got frames %0d errs %0d exp 1 5", frame_cnt_o, err_cnt_o);
    end
`else
    checks++;
    if (eof_crc !== 1'b0 || eof_err !== 1'b0) begin
      errors++;
      $display("FAIL crc_flag got crc %b err %b exp 0 0", eof_crc, eof_err);
    end
    checks++;
    if (frame_cnt_o !== 16'd2 || err_cnt_o !== 16'd4) begin
      errors++;
      $display("FAIL crc_cnt got frames %0d errs %0d exp 2 4", frame_cnt_o, err_cnt_o);
    end
`endif
  endtask

  task automatic test_mid_frame_reset();
    logic [55:0] outs;
    int e0;
    e0 = eofs;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < 20; i++) drive_byte(8'h3C);
    mr_main_reset = 1'b0;
    #1;
    outs = {rx_data_o, rx_valid_o, rx_sof_o, rx_eof_o, rx_err_o, crc_err_o,
            frame_len_o, frame_cnt_o, err_cnt_o};
    checks++;
    if (outs !== 56'h0 || dbg_state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_outs got %h state %0d exp 0 0", outs, dbg_state_o);
    end
    RX_DV = 1'b0;
    RXD   = 8'h00;
    repeat (3) begin
      @(posedge GTX_CLK); #1;
    end
    checks++;
    if (eofs !== e0 || rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_eof got %0d eofs valid %b exp 0 0", eofs - e0, rx_valid_o);
    end
    mr_main_reset = 1'b1;
    exp_q.delete();
    idle(2);
  endtask

  task automatic test_after_reset_and_back_to_back();
    int b0, e0, k0;
    b0 = beats; e0 = eofs; k0 = sb_bad;
    send_frame(64, 1'b0, 2);
    checks++;
    if (frame_cnt_o !== 16'd1 || err_cnt_o !== 16'd0 || eof_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got frames %0d errs %0d err %b exp 1 0 0", frame_cnt_o, err_cnt_o, eof_err);
    end
    b0 = beats; e0 = eofs;
    send_frame(64, 1'b0, 1);
    send_frame(64, 1'b0, 2);
    checks++;
    if (beats - b0 !== 128 || eofs - e0 !== 2 || sb_bad !== k0) begin
      errors++;
      $display("FAIL b2b_stream got beats %0d eofs %0d bad %0d exp 128 2 0", beats - b0, eofs - e0, sb_bad - k0);
    end
    checks++;
    if (frame_cnt_o !== 16'd3 || err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL b2b_cnt got frames %0d errs %0d exp 3 0", frame_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_short_frames();
    int b0, s0, e0, k0;
    b0 = beats; s0 = sofs; e0 = eofs; k0 = sb_bad;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    exp_q.push_back(8'hA5);
    drive_byte(8'hA5);
    idle(2);
    checks++;
    if (beats - b0 !== 1 || sofs - s0 !== 1 || eofs - e0 !== 1 || sof_at !== b0 + 1 || eof_at !== b0 + 1) begin
      errors++;
      $display("FAIL one_byte_marks got beats %0d sofs %0d eofs %0d exp 1 1 1", beats - b0, sofs - s0, eofs - e0);
    end
    checks++;
    if (eof_err !== 1'b1 || frame_len_o !== 11'd1 || err_cnt_o !== 16'd1 || sb_bad !== k0) begin
      errors++;
      $display("FAIL one_byte got err %b len %0d errs %0d bad %0d exp 1 1 1 0",
               eof_err, frame_len_o, err_cnt_o, sb_bad - k0);
    end
    b0 = beats; e0 = eofs;
    drive_byte(8'h55);
    drive_byte(8'hD5);
    idle(2);
    checks++;
    if (beats !== b0 || eofs !== e0 || err_cnt_o !== 16'd2 || frame_len_o !== 11'd1 || frame_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL empty_frame got beats %0d eofs %0d errs %0d len %0d frames %0d exp 0 0 2 1 3",
               beats - b0, eofs - e0, err_cnt_o, frame_len_o, frame_cnt_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_frame();
    test_length_errors();
    test_drop();
    test_crc_error();
    test_mid_frame_reset();
    test_after_reset_and_back_to_back();
    test_short_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
